// File: rtl/tick_bcd_counter_pkg.sv
// Shared BCD constants and the digit clamp used by the tick-driven BCD counter.
package tick_bcd_counter_pkg;

   localparam int DW = 4;
   localparam logic [DW-1:0] BCD_MAX  = 4'd9;
   localparam logic [DW-1:0] BCD_ZERO = 4'd0;

   // Any non-BCD nibble is forced to 9 so a preset can never leave an illegal digit.
   function automatic logic [DW-1:0] clamp_digit(input logic [DW-1:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/tick_bcd_counter_bcd_digit.sv
// One BCD digit of the up/down counter: holds its value, steps on carry/borrow in,
// and reports carry/borrow out when it rolls over.
module bcd_digit
   import tick_bcd_counter_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] load_val,
   input  logic          step,
   input  logic          up,
   output logic [DW-1:0] digit,
   output logic          carry
);

   logic          at_limit;
   logic [DW-1:0] next_digit;

   always_comb begin
      at_limit   = up ? (digit == BCD_MAX) : (digit == BCD_ZERO);
      carry      = step & at_limit;
      next_digit = digit;
      if (up)
         next_digit = at_limit ? BCD_ZERO : digit + 4'd1;
      else
         next_digit = at_limit ? BCD_MAX : digit - 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         digit <= BCD_ZERO;
      else if (load)
         digit <= clamp_digit(load_val);
      else if (step)
         digit <= next_digit;
   end

endmodule

// File: rtl/tick_bcd_counter.sv
// Synchronises the divided clock into CCLK, turns each rising edge into a one-cycle
// tick and advances a DIGITS-wide BCD up/down counter on that tick.
module tick_bcd_counter
   import tick_bcd_counter_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int SYNC_STAGES = 2
)
(
   input  logic                 CCLK,
   input  logic                 rst,
   input  logic                 clk_in,
   input  logic                 en,
   input  logic                 up,
   input  logic                 load,
   input  logic [DW*DIGITS-1:0] load_val,
   output logic [DW*DIGITS-1:0] bcd,
   output logic                 tick,
   output logic                 wrap
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   edge_q;
   logic                   rise;
   logic [DIGITS:0]        chain;

   // Synchroniser carries no reset; it flushes with the live clk_in level.
   always_ff @(posedge CCLK) begin
      sync <= {sync[SYNC_STAGES-2:0], clk_in};
   end

   // Tracking the sync output through reset means a level held high across release
   // is not seen as a new edge.
   always_ff @(posedge CCLK) begin
      edge_q <= sync[SYNC_STAGES-1];
   end

   assign rise     = sync[SYNC_STAGES-1] & ~edge_q;
   assign chain[0] = rise & en & ~load;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk      (CCLK),
         .rst      (rst),
         .load     (load),
         .load_val (load_val[g*DW +: DW]),
         .step     (chain[g]),
         .up       (up),
         .digit    (bcd[g*DW +: DW]),
         .carry    (chain[g+1])
      );
   end

   // Carry out of the top digit is exactly the all-9/all-0 rollover.
   always_ff @(posedge CCLK) begin
      if (rst) begin
         tick <= 1'b0;
         wrap <= 1'b0;
      end else begin
         tick <= rise;
         wrap <= chain[DIGITS];
      end
   end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Bench for tick_bcd_counter: directed tables, hand-written corner sequences and a
// randomized run against an integer-count reference model.
module tb_tick_bcd_counter;

   localparam int DIGITS = 4;
   localparam int S      = 2;
   localparam int W      = 4 * DIGITS;
   localparam int MOD    = 10000;

   logic         CCLK = 1'b0;
   logic         rst, clk_in, en, up, load;
   logic [W-1:0] load_val;
   logic [W-1:0] bcd;
   logic         tick, wrap;

   tick_bcd_counter #(.DIGITS(DIGITS), .SYNC_STAGES(S)) dut (
      .CCLK     (CCLK),
      .rst      (rst),
      .clk_in   (clk_in),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .bcd      (bcd),
      .tick     (tick),
      .wrap     (wrap)
   );

   always #5 CCLK = ~CCLK;

   int n_tests = 0;
   int n_fail  = 0;
   int m_count = 0;
   bit m_tick, m_wrap;
   bit hist[$];
   int tick_cnt = 0;
   int wrap_cnt = 0;

   typedef struct {
      logic [W-1:0] lv;
      logic [W-1:0] exp;
   } ld_vec_t;
   ld_vec_t vecs[5];

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic int clamp_val(input logic [W-1:0] v);
      int r, p, d;
      r = 0;
      p = 1;
      for (int k = 0; k < DIGITS; k++) begin
         d = int'(v[4*k +: 4]);
         if (d > 9) d = 9;
         r = r + d * p;
         p = p * 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One CCLK cycle: drive inputs, advance the model, compare after the edge.
   task automatic cyc(input bit r, input bit c, input bit e, input bit u,
                      input bit l, input logic [W-1:0] lv);
      bit rise;
      rst = r; clk_in = c; en = e; up = u; load = l; load_val = lv;
      @(posedge CCLK);
      hist.push_back(c);
      if (hist.size() > 8) void'(hist.pop_front());
      rise = 1'b0;
      if (hist.size() >= S + 2)
         rise = hist[hist.size()-1-S] && !hist[hist.size()-2-S];
      m_tick = !r && rise;
      m_wrap = 1'b0;
      if (r)
         m_count = 0;
      else if (l)
         m_count = clamp_val(lv);
      else if (rise && e) begin
         if (u) begin
            m_wrap  = (m_count == MOD - 1);
            m_count = (m_count + 1) % MOD;
         end else begin
            m_wrap  = (m_count == 0);
            m_count = (m_count + MOD - 1) % MOD;
         end
      end
      #1;
      check("model_bcd",  32'(bcd),  32'(to_bcd(m_count)));
      check("model_tick", 32'(tick), 32'(m_tick));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
      if (tick) tick_cnt++;
      if (wrap) wrap_cnt++;
   endtask

   task automatic period(input bit e, input bit u);
      for (int j = 0; j < 10; j++) cyc(1'b0, 1'b0, e, u, 1'b0, '0);
      for (int j = 0; j < 10; j++) cyc(1'b0, 1'b1, e, u, 1'b0, '0);
   endtask

   initial begin
      vecs[0] = '{lv: 16'h0A3F, exp: 16'h0939};
      vecs[1] = '{lv: 16'h1234, exp: 16'h1234};
      vecs[2] = '{lv: 16'hA0B0, exp: 16'h9090};
      vecs[3] = '{lv: 16'h0000, exp: 16'h0000};
      vecs[4] = '{lv: 16'hFFFF, exp: 16'h9999};

      // Reset with clk_in high, then hold: no tick, count zero.
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      check("reset_bcd",  32'(bcd),  32'h0);
      check("reset_tick", 32'(tick), 32'h0);
      check("reset_wrap", 32'(wrap), 32'h0);
      tick_cnt = 0;
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      check("release_no_tick", 32'(tick_cnt), 32'd0);
      check("release_bcd",     32'(bcd),      32'h0);

      // Twelve rises, tick exactly S+1 edges after each rise.
      tick_cnt = 0;
      for (int p = 0; p < 12; p++) begin
         for (int j = 0; j < 10; j++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
         for (int j = 0; j < 10; j++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
            if (j == S || j == S - 1 || j == S + 1)
               check("tick_latency", 32'(tick), (j == S) ? 32'd1 : 32'd0);
         end
      end
      check("count12_ticks", 32'(tick_cnt), 32'd12);
      check("count12_bcd",   32'(bcd),      32'h0012);

      // Up wrap from 9998.
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h9998);
      wrap_cnt = 0;
      period(1'b1, 1'b1);
      check("up_9999_bcd",  32'(bcd),      32'h9999);
      check("up_9999_wrap", 32'(wrap_cnt), 32'd0);
      period(1'b1, 1'b1);
      check("up_wrap_bcd",  32'(bcd),      32'h0000);
      check("up_wrap_wrap", 32'(wrap_cnt), 32'd1);

      // Down wrap from 0000.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
      wrap_cnt = 0;
      period(1'b1, 1'b0);
      check("down_wrap_bcd",  32'(bcd),      32'h9999);
      check("down_wrap_wrap", 32'(wrap_cnt), 32'd1);

      // Load clamp table.
      foreach (vecs[i]) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, vecs[i].lv);
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
         check("load_clamp", 32'(bcd), 32'(vecs[i].exp));
      end

      // Load coinciding with the rise edge: from 9999 an up-count would wrap.
      for (int j = 0; j < 10; j++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      for (int j = 0; j < 10; j++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b1, bit'(j == S), 16'h0500);
         if (j == S) begin
            check("load_rise_bcd",  32'(bcd),  32'h0500);
            check("load_rise_tick", 32'(tick), 32'd1);
            check("load_rise_wrap", 32'(wrap), 32'd0);
         end
      end
      tick_cnt = 0;
      wrap_cnt = 0;
      for (int p = 0; p < 3; p++) period(1'b0, 1'b1);
      check("hold_ticks", 32'(tick_cnt), 32'd3);
      check("hold_bcd",   32'(bcd),      32'h0500);
      check("hold_wrap",  32'(wrap_cnt), 32'd0);

      // Reset while a rise is still inside the synchroniser.
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0041);
      period(1'b1, 1'b1);
      check("pre_rst_bcd", 32'(bcd), 32'h0042);
      for (int j = 0; j < 10; j++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      tick_cnt = 0;
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      check("mid_rst_bcd",  32'(bcd),  32'h0000);
      check("mid_rst_tick", 32'(tick), 32'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      for (int j = 0; j < 10; j++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0);
      check("pending_edge_dropped", 32'(tick_cnt), 32'd0);
      check("post_rst_bcd",         32'(bcd),      32'h0000);

      // Randomized run, including pulses too short to be guaranteed.
      for (int i = 0; i < 200; i++) begin
         bit lvl;
         int len;
         lvl = bit'($urandom_range(0, 1));
         len = int'($urandom_range(1, 6));
         for (int j = 0; j < len; j++)
            cyc(bit'($urandom_range(0, 99) == 0), lvl,
                bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 19) == 0), W'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
